mem_port_arbiter: RTL and testbench

//  Shares one multi-cycle memory port between the IF stage (instruction fetch) and the MEM stage
//  (load/store) of the pipelined RV32I core. Grants one requester at a time, sequences the memory

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one multi-cycle memory port between IF fetches and MEM loads/stores, with abort on timeout.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie breaking; undefined gives fixed D-over-I priority.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } xfer_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic [3:0]    mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_done_q, i_done_d;
    logic          d_done_q, d_done_d;
    logic          bus_err_q, bus_err_d;
    logic          pick_d;
    logic          timeout_hit;
    xfer_t         win;

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_grant_q, last_grant_d;  // 1 = D was granted last

    always_comb pick_d = d_req & (~i_req | ~last_grant_q);
`else
    always_comb pick_d = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        win = pick_d ? '{addr: d_addr, we: d_we, wdata: d_wdata}
                     : '{addr: i_addr, we: 4'b0000, wdata: 32'h0};
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

        unique case (state_q)
            IDLE: begin
                if (i_req | d_req) begin
                    state_d     = pick_d ? GNT_D : GNT_I;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = win.addr & 32'hFFFF_FFFC;
                    mem_we_d    = win.we;
                    mem_wdata_d = win.wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = pick_d;
`endif
                end
            end
            GNT_I, GNT_D: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack || timeout_hit) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 4'b0000;
                    bus_err_d = ~mem_ack;
                    if (state_q == GNT_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem_ack ? mem_rdata : 32'h0;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : 32'h0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

    // Stalls are forced low during reset so the hazard unit sees no bubbles.
    assign i_stall = i_req & ~i_done_q & ~rst;
    assign d_stall = d_req & ~d_done_q & ~rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_done, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_done, d_stall;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_ack, bus_err;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Requester-side model: what each requester currently asks for, and who was served last.
    logic        i_pend, d_pend, lg, rand_on;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dwe;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        i_req = i_pend; i_addr = ia;
        d_req = d_pend; d_addr = da; d_we = dwe; d_wdata = dwd;
    endtask

    task automatic new_i();
        i_pend = 1'b1; ia = $urandom;
    endtask

    task automatic new_d();
        d_pend = 1'b1; da = $urandom; dwd = $urandom;
        dwe = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    endtask

    task automatic chk_stalls(input logic idn, input logic ddn);
        #1;
        chk("i_stall", 32'(i_stall), 32'(i_pend & ~idn));
        chk("d_stall", 32'(d_stall), 32'(d_pend & ~ddn));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_i_done"},  32'(i_done),  32'd0);
        chk({tag, "_d_done"},  32'(d_done),  32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    // One full transaction starting in an IDLE cycle with at least one request pending.
    // k = grant cycle in which memory acks; k > TO means memory never answers.
    task automatic serve(input int k, input logic [31:0] rdv);
        logic        w, tmo;
        int          n;
        logic [31:0] ea, ewd, erd;
        logic [3:0]  ewe;
`ifdef ARB_ROUND_ROBIN_EN
        w = (i_pend && d_pend) ? ~lg : d_pend;
`else
        w = d_pend;
`endif
        lg  = w;
        ea  = (w ? da : ia) & 32'hFFFF_FFFC;
        ewe = w ? dwe : 4'b0000;
        ewd = dwd;
        tmo = (k > TO);
        n   = tmo ? TO : k;
        erd = tmo ? 32'h0 : rdv;
        for (int c = 1; c <= n; c++) begin
            tick();
            chk("gnt_mem_req", 32'(mem_req), 32'd1);
            chk("gnt_mem_addr", mem_addr, ea);
            chk("gnt_mem_we", 32'(mem_we), 32'(ewe));
            if (w) chk("gnt_mem_wdata", mem_wdata, ewd);
            chk("gnt_i_done", 32'(i_done), 32'd0);
            chk("gnt_d_done", 32'(d_done), 32'd0);
            chk("gnt_bus_err", 32'(bus_err), 32'd0);
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? rdv : $urandom;
            if (rand_on && $urandom_range(0, 3) == 0) begin
                if (w && !i_pend) begin new_i(); i_req = 1'b1; i_addr = ia; end
                if (!w && !d_pend) begin
                    new_d(); d_req = 1'b1; d_addr = da; d_we = dwe; d_wdata = dwd;
                end
            end
            // The granted requester's payload is scrambled: only the values latched at grant count.
            if (w) begin d_addr = $urandom; d_wdata = $urandom; d_we = 4'($urandom); end
            else i_addr = $urandom;
            chk_stalls(1'b0, 1'b0);
        end
        tick();
        chk("resp_i_done", 32'(i_done), 32'(!w));
        chk("resp_d_done", 32'(d_done), 32'(w));
        if (w) chk("resp_d_rdata", d_rdata, erd);
        else   chk("resp_i_rdata", i_rdata, erd);
        chk("resp_bus_err", 32'(bus_err), 32'(tmo));
        chk("resp_mem_req", 32'(mem_req), 32'd0);
        mem_ack   = rand_on ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        if (w) d_pend = 1'b0; else i_pend = 1'b0;
        if (rand_on && $urandom_range(0, 1) == 1) begin
            if (w) new_d(); else new_i();
        end
        drive_reqs();
        chk_stalls(!w, w);
        tick();
        mem_ack = 1'b0;
        chk_quiet("idle");
    endtask

    task automatic round();
        if (!i_pend && !d_pend) begin
            case ($urandom_range(0, 3))
                0: new_i();
                1: new_d();
                2: begin new_i(); new_d(); end
                default: ;
            endcase
            drive_reqs();
        end
        if (i_pend || d_pend) begin
            chk_stalls(1'b0, 1'b0);
            serve($urandom_range(1, TO + 3), $urandom);
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            chk_stalls(1'b0, 1'b0);
            tick();
            mem_ack = 1'b0;
            chk_quiet("stray");
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; rand_on = 1'b0; lg = 1'b0;
        i_pend = 1'b1; d_pend = 1'b1; ia = 32'h40; da = 32'h80; dwe = 4'b0000; dwd = 32'h0;
        drive_reqs();
        tick(); tick();
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_i_stall", 32'(i_stall), 32'd0);
        chk("rst_d_stall", 32'(d_stall), 32'd0);
        chk_quiet("rst");
        i_pend = 1'b0; d_pend = 1'b0; drive_reqs(); rst = 1'b0;
        tick();
        chk_quiet("post_rst");

        // Load, ack in the third grant cycle
        d_pend = 1'b1; da = 32'h100; dwe = 4'b0000; dwd = 32'h0; drive_reqs();
        chk_stalls(1'b0, 1'b0);
        serve(3, 32'hDEADBEEF);

        // Store with an unaligned address
        d_pend = 1'b1; da = 32'h203; dwe = 4'b0011; dwd = 32'h1234_5678; drive_reqs();
        chk_stalls(1'b0, 1'b0);
        serve(2, 32'hCAFE_0001);

        // Tie: both requesters at once, then the loser is served next
        i_pend = 1'b1; ia = 32'h1000; d_pend = 1'b1; da = 32'h2004; dwe = 4'b0000; drive_reqs();
        chk_stalls(1'b0, 1'b0);
        serve(1, 32'h0000_AAAA);
        chk_stalls(1'b0, 1'b0);
        serve(1, 32'h0000_BBBB);

        // Timeouts on each side
        d_pend = 1'b1; da = 32'h3000; dwe = 4'b1111; dwd = 32'h5555_AAAA; drive_reqs();
        chk_stalls(1'b0, 1'b0);
        serve(TO + 5, 32'h1111_1111);
        i_pend = 1'b1; ia = 32'h4008; drive_reqs();
        chk_stalls(1'b0, 1'b0);
        serve(TO + 1, 32'h2222_2222);

        // Reset in the second grant cycle, followed by a late ack
        d_pend = 1'b1; da = 32'h5000; dwe = 4'b0000; drive_reqs();
        tick();
        chk("rm_mem_req_g1", 32'(mem_req), 32'd1);
        tick();
        chk("rm_mem_req_g2", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_d_stall_in_rst", 32'(d_stall), 32'd0);
        tick();
        chk_quiet("rm_c3");
        chk("rm_d_rdata", d_rdata, 32'h0);
        rst = 1'b0; d_pend = 1'b0; drive_reqs();
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        tick();
        mem_ack = 1'b0;
        chk_quiet("rm_c4");
        tick();
        chk_quiet("rm_c5");
        lg = 1'b0;

        rand_on = 1'b1;
        repeat (300) round();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
